mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single multicycle main memory (1-cycle write, 4-cycle pipelined read) between I-cache and D-cache.
//  - Arbitrates miss and write requests.
//  - Sequences an 8-word block fill as back-to-back pipelined reads and steers returning words to the owner.
//  - Passes D-cache write-through stores to memory as single-cycle writes.
// PARAMETERS
//  ADDR_WIDTH   16  byte-address width; bit 0 of every memory address driven is 0
//  BLOCK_WORDS  8   16-bit words per cache block; power of 2; block = 2*BLOCK_WORDS bytes
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous reset, active-high
//  i_req          in   1   I-cache block fill request; held until i_done
//  i_addr         in   AW  I-cache miss byte address
//  d_req          in   1   D-cache request; held until d_done (read) or d_wr_ack (write)
//  d_wr           in   1   1 = single-word write, 0 = block fill
//  d_addr         in   AW  D-cache byte address
//  d_wdata        in   16  D-cache write data
//  fill_data      out  16  returning word; shared by both requesters
//  fill_idx       out  log2(BW)  word index within the block for fill_data
//  i_fill_valid   out  1   fill_data is valid for I-cache
//  d_fill_valid   out  1   fill_data is valid for D-cache
//  i_done         out  1   1-cycle pulse with the last I fill word
//  d_done         out  1   1-cycle pulse with the last D fill word
//  d_wr_ack       out  1   1-cycle pulse in the cycle the D write reaches memory
//  busy           out  1   state != IDLE
//  mem_enable     out  1   to memory enable
//  mem_wr         out  1   to memory wr
//  mem_addr       out  AW  to memory addr
//  mem_data_in    out  16  to memory data_in
//  mem_data_out   in   16  from memory data_out
//  mem_data_valid in   1   from memory data_valid; 4 cycles after the read enable
// BEHAVIOUR
//  - States:
//    - IDLE: samples requests.
//    - ISSUE: drives BLOCK_WORDS reads.
//    - DRAIN: waits for the outstanding returns.
//    - WRITE: drives a single write cycle.
//  - Reset: state=IDLE, issue_cnt=0, ret_cnt=0, owner=D, last_grant=I. Every output is 0.
//  - IDLE grant: on a grant, latch owner, base=addr & ~(2*BW-1), wdata.
//    - D grant with d_wr=1 -> WRITE.
//    - Any other grant -> ISSUE.
//  - ISSUE: drives mem_enable=1, mem_wr=0, mem_addr=base+2*issue_cnt. issue_cnt increments every cycle.
//    - After word BW-1 is issued -> DRAIN.
//    - Reads therefore issue in cycles 0..BW-1 after grant.
//  - Returns: each mem_data_valid, in ISSUE or DRAIN, does three things:
//    - fill_data=mem_data_out and fill_idx=ret_cnt;
//    - the owner's *_fill_valid=1;
//    - ret_cnt increments.
//    Returns overlap ISSUE; words arrive in cycles 4..BW+3.
//  - Done: the return with ret_cnt==BW-1 also pulses the owner's done. The next state is IDLE.
//    - BW=8: 12 cycles from the grant cycle through done.
//  - WRITE: exactly one cycle, driving mem_enable=1, mem_wr=1, mem_addr=latched d_addr (bit0 cleared), mem_data_in=wdata.
//    - d_wr_ack pulses in that same cycle. The next state is IDLE.
//  - Writes are granted only from IDLE, so no write ever overlaps in-flight reads.
//  - Requester must drop req in the cycle after done/ack; IDLE re-samples from that cycle.
//  - In IDLE, mem_enable=0. fill_data/fill_idx hold their last value; valids are 0 except during returns.
//  - A mem_data_valid seen in IDLE or WRITE is ignored. It cannot occur in legal operation.
//  - Requests arriving while busy wait; they are never dropped.
//  - Reset mid-fill: the operation is abandoned with no done pulse. Memory resets on the same rst, so no stale returns follow.
//  - Address arithmetic is modulo 2^AW; low bits are taken from the counter, never carried.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN
//    - Undefined: fixed priority; D wins whenever d_req=1 in IDLE.
//    - Defined: if both request, grant the requester that is not last_grant. last_grant updates on every grant.
//      A single requester is always granted.
// TESTING
//  1. I fill, i_addr=0x0036 -> reads 0x0030..0x003E (cycles 0-7). i_fill_valid in cycles 4-11, idx 0..7, data=mem words. i_done at cycle 11.
//  2. D write, d_addr=0x1235, d_wdata=0xBEEF -> one cycle with mem_wr=1, mem_addr=0x1234, d_wr_ack=1. A following D fill returns 0xBEEF at idx 2.
//  3. i_req and d_req (fill) in the same cycle -> default build: D served first, I granted the cycle after d_done. RR build from reset: D first, then I.
//  4. RR build, both requesting continuously across 4 operations -> grants alternate D,I,D,I. Default build: D,D,D,D.
//  5. rst asserted in cycle 6 of a D fill -> all outputs 0 next cycle, no d_done. A fresh I fill completes normally.
//  6. i_addr=0xFFF2 -> reads 0xFFF0..0xFFFE with no wrap past 0xFFFE. i_done after 8 returns.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main memory between the I-cache and D-cache.
// Block fills issue BLOCK_WORDS back-to-back reads and steer the returns to the owner.
// D-cache write-through stores become single-cycle memory writes.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate grants when both caches request.
// Without the macro, the D-cache has fixed priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_req,
  input  logic [ADDR_WIDTH-1:0]          i_addr,
  input  logic                           d_req,
  input  logic                           d_wr,
  input  logic [ADDR_WIDTH-1:0]          d_addr,
  input  logic [15:0]                    d_wdata,
  output logic [15:0]                    fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
  output logic                           i_fill_valid,
  output logic                           d_fill_valid,
  output logic                           i_done,
  output logic                           d_done,
  output logic                           d_wr_ack,
  output logic                           busy,
  output logic                           mem_enable,
  output logic                           mem_wr,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [15:0]                    mem_data_in,
  input  logic [15:0]                    mem_data_out,
  input  logic                           mem_data_valid
);
  localparam int IW  = $clog2(BLOCK_WORDS);
  localparam int OFF = IW + 1;  // byte-offset bits inside a block

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         issue_cnt_q, issue_cnt_d;
  logic [IW-1:0]         ret_cnt_q, ret_cnt_d;
  logic                  owner_q, owner_d;  // 1 = D-cache
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;    // bit 0 always stored as 0
  logic [15:0]           wdata_q, wdata_d;
  logic [15:0]           fill_data_q, fill_data_d;
  logic [IW-1:0]         fill_idx_q, fill_idx_d;
  logic                  grant_d, grant_i;
  logic                  ret_fire, last_ret;
`ifdef ARB_ROUND_ROBIN_EN
  logic                  last_grant_q, last_grant_d;  // 1 = D-cache
`endif

  // Grant selection, only meaningful in IDLE
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    grant_d = d_req && (!i_req || !last_grant_q);
`else
    grant_d = d_req;
`endif
    grant_i = i_req && !grant_d;
  end

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      owner_q     <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      fill_data_q <= '0;
      fill_idx_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      fill_data_q <= fill_data_d;
      fill_idx_q  <= fill_idx_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Next-state, counters and memory-side outputs
  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    fill_data_d  = fill_data_q;
    fill_idx_d   = fill_idx_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    d_wr_ack     = 1'b0;
    fill_data    = fill_data_q;
    fill_idx     = fill_idx_q;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    i_done       = 1'b0;
    d_done       = 1'b0;

    // Returns count only while a fill is in flight; strays elsewhere are ignored
    ret_fire = mem_data_valid && (state_q == S_ISSUE || state_q == S_DRAIN);
    last_ret = ret_fire && (ret_cnt_q == IW'(BLOCK_WORDS - 1));

    if (ret_fire) begin
      fill_data    = mem_data_out;
      fill_idx     = ret_cnt_q;
      fill_data_d  = mem_data_out;
      fill_idx_d   = ret_cnt_q;
      i_fill_valid = !owner_q;
      d_fill_valid = owner_q;
      i_done       = last_ret && !owner_q;
      d_done       = last_ret && owner_q;
      ret_cnt_d    = ret_cnt_q + IW'(1);
    end

    case (state_q)
      S_IDLE: begin
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        if (grant_d || grant_i) begin
          owner_d = grant_d;
          addr_d  = grant_d ? {d_addr[ADDR_WIDTH-1:1], 1'b0} : {i_addr[ADDR_WIDTH-1:1], 1'b0};
          if (grant_d) wdata_d = d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = grant_d;
`endif
          state_d = (grant_d && d_wr) ? S_WRITE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_enable  = 1'b1;
        // Word index comes straight from the counter, so the block never carries upward
        mem_addr    = {addr_q[ADDR_WIDTH-1:OFF], issue_cnt_q, 1'b0};
        issue_cnt_d = issue_cnt_q + IW'(1);
        if (issue_cnt_q == IW'(BLOCK_WORDS - 1)) state_d = S_DRAIN;
        if (last_ret) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (last_ret) state_d = S_IDLE;
      end
      S_WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = addr_q;
        mem_data_in = wdata_q;
        d_wr_ack    = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a 4-cycle pipelined memory model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [15:0] fill_data;
  logic [2:0]  fill_idx;
  logic        i_fill_valid, d_fill_valid, i_done, d_done, d_wr_ack, busy;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_data_valid;

  int n_cmp = 0;
  int n_bad = 0;
  bit beef_written = 1'b0;

  mem_arbiter #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .fill_data(fill_data), .fill_idx(fill_idx),
    .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .i_done(i_done), .d_done(d_done), .d_wr_ack(d_wr_ack), .busy(busy),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  // Memory model: 1-cycle write, read data valid 4 cycles after the enable
  logic [15:0] mem [0:32767];
  logic [3:0]  rv;
  logic [15:0] rd [4];
  always @(posedge clk) begin
    if (rst) begin
      rv <= '0;
    end else begin
      rv    <= {rv[2:0], mem_enable && !mem_wr};
      rd[0] <= mem[mem_addr[15:1]];
      rd[1] <= rd[0];
      rd[2] <= rd[1];
      rd[3] <= rd[2];
      if (mem_enable && mem_wr) mem[mem_addr[15:1]] <= mem_data_in;
    end
  end
  assign mem_data_valid = rv[3];
  assign mem_data_out   = rd[3];

  function automatic logic [15:0] exp_word(input logic [15:0] a);
    if (beef_written && a == 16'h1234) return 16'hBEEF;
    return a ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Waits for the first read cycle, then checks the 12-cycle fill; returns in cycle 11
  task automatic run_fill(input bit own_d, input logic [15:0] addr, input bit keep, output int waited);
    logic [15:0] base;
    base = addr & 16'hFFF0;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!mem_enable && waited < 40);
    chk("grant_seen", mem_enable, 1);
    if (!mem_enable) return;
    for (int c = 0; c < 12; c++) begin
      chk("rd_en", mem_enable, c < 8);
      chk("rd_wr", mem_wr, 0);
      if (c < 8) chk("rd_addr", mem_addr, base + 16'(2 * c));
      chk("i_vld", i_fill_valid, !own_d && c >= 4);
      chk("d_vld", d_fill_valid, own_d && c >= 4);
      if (c >= 4) begin
        chk("f_idx", fill_idx, c - 4);
        chk("f_data", fill_data, exp_word(base + 16'(2 * (c - 4))));
      end
      chk("i_done", i_done, !own_d && c == 11);
      chk("d_done", d_done, own_d && c == 11);
      if (c == 11 && !keep) begin
        if (own_d) d_req = 1'b0; else i_req = 1'b0;
      end
      if (c < 11) tick();
    end
  endtask

  initial begin
    int w;
    bit exp_d;
    for (int k = 0; k < 32768; k++) mem[k] = 16'(2 * k) ^ 16'h5A5A;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    do_reset();

    // Reset state: every output 0
    rst = 1'b1; tick();
    chk("rst_busy", busy, 0);
    chk("rst_men", mem_enable, 0);
    chk("rst_mwr", mem_wr, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mdin", mem_data_in, 0);
    chk("rst_fdata", fill_data, 0);
    chk("rst_fidx", fill_idx, 0);
    chk("rst_vld", {i_fill_valid, d_fill_valid, i_done, d_done, d_wr_ack}, 0);
    rst = 1'b0; tick();

    // I fill from 0x0036
    i_addr = 16'h0036; i_req = 1'b1;
    run_fill(0, 16'h0036, 0, w);
    chk("t1_lat", w, 1);
    tick();
    chk("t1_idle", busy, 0);

    // D write then D fill of the same block
    d_addr = 16'h1235; d_wdata = 16'hBEEF; d_wr = 1'b1; d_req = 1'b1;
    tick();
    chk("wr_en", mem_enable, 1);
    chk("wr_wr", mem_wr, 1);
    chk("wr_addr", mem_addr, 16'h1234);
    chk("wr_data", mem_data_in, 16'hBEEF);
    chk("wr_ack", d_wr_ack, 1);
    chk("wr_busy", busy, 1);
    d_req = 1'b0; d_wr = 1'b0;
    beef_written = 1'b1;
    tick();
    chk("wr_ack_end", d_wr_ack, 0);
    chk("wr_idle", busy, 0);
    d_addr = 16'h1230; d_req = 1'b1;
    run_fill(1, 16'h1230, 0, w);
    tick();

    // Simultaneous I and D fills from reset
    do_reset();
    i_addr = 16'h0100; d_addr = 16'h0200; i_req = 1'b1; d_req = 1'b1;
    run_fill(1, 16'h0200, 0, w);
    run_fill(0, 16'h0100, 0, w);
    chk("t3_i_next", w, 2);
    tick();

    // Both requesting continuously for 4 operations
    do_reset();
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      run_fill(exp_d, exp_d ? 16'h0200 : 16'h0100, 1, w);
      chk("t4_gap", w, (k == 0) ? 1 : 2);
    end
    i_req = 1'b0; d_req = 1'b0;
    tick(); tick();

    // Reset in cycle 6 of a D fill
    do_reset();
    d_addr = 16'h0400; d_req = 1'b1;
    w = 0;
    do begin tick(); w++; end while (!mem_enable && w < 40);
    chk("t5_start", mem_enable, 1);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_men", mem_enable, 0);
    chk("t5_maddr", mem_addr, 0);
    chk("t5_fdata", fill_data, 0);
    chk("t5_fidx", fill_idx, 0);
    chk("t5_out", {i_fill_valid, d_fill_valid, i_done, d_done, d_wr_ack}, 0);
    rst = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t5_quiet", {d_fill_valid, d_done, busy}, 0);
    end

    // Top-of-memory block: no wrap past 0xFFFE
    i_addr = 16'hFFF2; i_req = 1'b1;
    run_fill(0, 16'hFFF2, 0, w);
    tick();
    chk("t6_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
